// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: single-outstanding AHB slave bridging onto an APB
// segment of NUM_PSLV peripherals. The AHB data phase is stretched
// (hreadyout=0) while the APB SETUP/ACCESS sequence runs.
//
// Optional feature: define APB_TIMEOUT_EN to abandon an ACCESS phase
// that has waited TIMEOUT_CYCLES cycles for pready (answered as ERROR).
//
// Ports:
//   hclk, hreset      clock, synchronous active-high reset
//   ahb_in            fabric master bundle (haddr, htrans, hwrite, hwdata)
//   hsel, hready_in   slave select, bus HREADY
//   ahb_out           hreadyout, hrdata, hresp back to the fabric
//   paddr, psel,
//   penable, pwrite,
//   pwdata            APB request side
//   prdata, pready,
//   pslverr           APB completion side

package ahb_apb_pkg;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
  } mas_send_type;

  typedef struct packed {
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;
  } slv_send_type;

endpackage

module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int NUM_PSLV       = 4,
  parameter int PSEL_LSB       = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                hclk,
  input  logic                hreset,
  input  mas_send_type        ahb_in,
  input  logic                hsel,
  input  logic                hready_in,
  output slv_send_type        ahb_out,
  output logic [31:0]         paddr,
  output logic [NUM_PSLV-1:0] psel,
  output logic                penable,
  output logic                pwrite,
  output logic [31:0]         pwdata,
  input  logic [31:0]         prdata,
  input  logic                pready,
  input  logic                pslverr
);

  // One spare index bit so addresses just above the last peripheral
  // decode as errors instead of aliasing onto a real one.
  localparam int IDXW = $clog2(NUM_PSLV) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]     paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [31:0]     hrdata_q, hrdata_d;

  logic            rdy_state;
  logic            accept;
  logic [IDXW-1:0] idx_in;
  logic            idx_ok;
  logic            apb_busy;

  // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  logic unused_htrans0;
  assign unused_htrans0 = ahb_in.htrans[0];

`ifdef APB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            limit;
  assign limit = (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
`endif

  assign idx_in = ahb_in.haddr[PSEL_LSB +: IDXW];
  assign idx_ok = (idx_in < IDXW'(NUM_PSLV));

  // Address phase is only sampled in states that drive hreadyout=1.
  assign rdy_state = (state_q == S_IDLE)
                   | (state_q == S_RESP)
                   | (state_q == S_ERR2);

  assign accept = rdy_state & hsel & hready_in
                & ahb_in.htrans[1];

  // Next state and datapath
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    idx_d    = idx_q;
    hrdata_d = hrdata_q;
`ifdef APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE, S_RESP, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          paddr_d  = ahb_in.haddr;
          pwrite_d = ahb_in.hwrite;
          idx_d    = idx_in;
          state_d  = idx_ok ? S_SETUP : S_ERR1;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        // pready is checked first so a completion in the
        // limit cycle still succeeds.
        if (pready) begin
          if (pslverr) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_RESP;
            if (!pwrite_q) hrdata_d = prdata;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (limit) begin
          state_d = S_ERR1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      hrdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      idx_q    <= idx_d;
      hrdata_q <= hrdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Outputs, all decoded from registered state
  assign apb_busy = (state_q == S_SETUP)
                  | (state_q == S_ACCESS);

  assign psel    = apb_busy
                 ? (NUM_PSLV'(1) << idx_q)
                 : '0;
  assign penable = (state_q == S_ACCESS);
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;

  // hwdata is held by the master for the whole stretched data phase.
  assign pwdata  = (|psel) ? ahb_in.hwdata : '0;

  assign ahb_out = '{
    hreadyout: rdy_state,
    hrdata:    hrdata_q,
    hresp:     (state_q == S_ERR1) | (state_q == S_ERR2)
  };

  a_psel_onehot: assert property (
    @(posedge hclk) disable iff (hreset)
    $onehot0(psel)
  );

  a_penable_sel: assert property (
    @(posedge hclk) disable iff (hreset)
    penable |-> (|psel)
  );

  a_err_two_cycle: assert property (
    @(posedge hclk) disable iff (hreset)
    (state_q == S_ERR1) |=> (state_q == S_ERR2)
  );

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed vectors for ahb_apb_bridge with a
// response scoreboard and an APB-side expectation queue.

module tb_ahb_apb_bridge;
  import ahb_apb_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          waits;
    logic [3:0]  psel;
    int          lat;
    logic        hresp;
    logic [31:0] hrdata;
    int          pcyc;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        hresp;
    logic [31:0] hrdata;
  } rsp_t;

  typedef struct {
    int          setup;
    int          ncyc;
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
  } apb_t;

  logic         hclk = 1'b0;
  logic         hreset = 1'b1;
  logic         hsel = 1'b0;
  logic         hready_in = 1'b1;
  mas_send_type ahb_in = '0;
  slv_send_type ahb_out;
  logic [31:0]  paddr;
  logic [3:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [31:0]  prdata = '0;
  logic         pready;
  logic         pslverr = 1'b0;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc = 0;
  int   wait_n = 0;
  logic in_reset = 1'b1;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  vec_t vt[14];

  ahb_apb_bridge #(
    .NUM_PSLV(4),
    .PSEL_LSB(12),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .ahb_in(ahb_in),
    .hsel(hsel),
    .hready_in(hready_in),
    .ahb_out(ahb_out),
    .paddr(paddr),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) cyc <= cyc + 1;

  // APB slave: pready after wait_n ACCESS cycles
  always @(posedge hclk)
    acc <= (penable && !pready) ? acc + 1 : 0;
  assign pready = penable && (acc >= wait_n);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic miss(input string nm, input string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", nm, what);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge hclk);
    while (!ahb_out.hreadyout) begin
      if (n == 200) begin
        miss("hready_wait",
             "hreadyout still 0 after 200 cycles, required 1");
        return;
      end
      @(negedge hclk);
      n++;
    end
  endtask

  task automatic issue(input vec_t v);
    int   t;
    rsp_t r;
    apb_t a;
    wait_ready();
    t = cyc;
    prdata = v.rd;
    pslverr = v.err;
    wait_n = v.waits;
    hsel = 1'b1;
    hready_in = 1'b1;
    ahb_in.haddr = v.a;
    ahb_in.hwrite = v.w;
    ahb_in.htrans = 2'b10;
    if (v.lat >= 0) begin
      r.cyc = t + v.lat;
      r.hresp = v.hresp;
      r.hrdata = v.hrdata;
      rsp_q.push_back(r);
    end
    if (v.psel != 4'b0000) begin
      a.setup = t + 1;
      a.ncyc = v.pcyc;
      a.psel = v.psel;
      a.paddr = v.a;
      a.pwrite = v.w;
      a.pwdata = v.wd;
      apb_q.push_back(a);
    end
    @(posedge hclk);
    #1;
    ahb_in.htrans = 2'b00;
    ahb_in.hwdata = v.wd;
  endtask

  // Transfers that must be ignored
  task automatic noise();
    wait_ready();
    hsel = 1'b1;
    hready_in = 1'b1;
    ahb_in.haddr = 32'h0000_2000;
    ahb_in.htrans = 2'b01;
    @(negedge hclk);
    hsel = 1'b0;
    ahb_in.htrans = 2'b10;
    @(negedge hclk);
    hsel = 1'b1;
    hready_in = 1'b0;
    @(negedge hclk);
    hready_in = 1'b1;
    ahb_in.htrans = 2'b00;
    repeat (3) @(negedge hclk);
  endtask

  // Monitor
  logic       prev_rdy = 1'b1;
  logic       prev_resp = 1'b0;
  logic [3:0] prev_psel = '0;
  int         pc = 0;
  rsp_t       mr;
  apb_t       ma;

  always @(negedge hclk) begin
    if (!in_reset && ahb_out.hreadyout && !prev_rdy) begin
      if (rsp_q.size() == 0) begin
        miss("rsp_unexpected",
             $sformatf("response hresp=%0d, required none",
                       ahb_out.hresp));
      end else begin
        mr = rsp_q.pop_front();
        chk("done_cycle", cyc, mr.cyc);
        chk("hresp", 32'(ahb_out.hresp), 32'(mr.hresp));
        chk("hrdata", ahb_out.hrdata, mr.hrdata);
        if (mr.hresp)
          chk("err1_hresp", 32'(prev_resp), 32'd1);
      end
    end
    if (psel != 4'b0000) begin
      if (apb_q.size() == 0) begin
        miss("apb_unexpected",
             $sformatf("psel=%b, required 0000", psel));
      end else begin
        ma = apb_q[0];
        if (prev_psel == 4'b0000) begin
          chk("setup_cycle", cyc, ma.setup);
          chk("setup_penable", 32'(penable), 32'd0);
        end
        chk("psel", 32'(psel), 32'(ma.psel));
        chk("paddr", paddr, ma.paddr);
        chk("pwrite", 32'(pwrite), 32'(ma.pwrite));
        chk("pwdata", pwdata, ma.pwdata);
      end
      pc <= (prev_psel == 4'b0000) ? 1 : pc + 1;
    end else if (prev_psel != 4'b0000 && apb_q.size() != 0) begin
      ma = apb_q.pop_front();
      chk("psel_cycles", pc, ma.ncyc);
    end
    prev_rdy <= ahb_out.hreadyout;
    prev_resp <= ahb_out.hresp;
    prev_psel <= psel;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // a, w, wd, rd, err, waits, psel, lat, hresp, hrdata, pcyc
    vt[0]  = '{32'h0000_2010, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0,
               0, 4'b0100, 3, 1'b0, 32'hDEAD_BEEF, 2};
    vt[1]  = '{32'h0000_1004, 1'b1, 32'h1234_5678, 32'h0, 1'b0,
               3, 4'b0010, 6, 1'b0, 32'hDEAD_BEEF, 5};
    vt[2]  = '{32'h0000_0008, 1'b0, 32'h0, 32'hBAD0_BAD0, 1'b1,
               0, 4'b0001, 4, 1'b1, 32'hDEAD_BEEF, 2};
    vt[3]  = '{32'h0000_7000, 1'b0, 32'h0, 32'h1111_0000, 1'b0,
               0, 4'b0000, 2, 1'b1, 32'hDEAD_BEEF, 0};
    vt[4]  = '{32'h0000_3FFC, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0,
               1, 4'b1000, 4, 1'b0, 32'hA5A5_0001, 3};
    vt[5]  = '{32'h0000_4000, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0,
               0, 4'b0000, 2, 1'b1, 32'hA5A5_0001, 0};
    vt[6]  = '{32'h0000_0100, 1'b1, 32'h0BAD_CAFE, 32'h0, 1'b1,
               0, 4'b0001, 4, 1'b1, 32'hA5A5_0001, 2};
    vt[7]  = '{32'h0000_3000, 1'b0, 32'h0, 32'h5A5A_5A5A, 1'b0,
               2, 4'b1000, 5, 1'b0, 32'h5A5A_5A5A, 4};
    vt[8]  = '{32'h0000_1FF0, 1'b0, 32'h0, 32'h00C0_FFEE, 1'b0,
               0, 4'b0010, 3, 1'b0, 32'h00C0_FFEE, 2};
    vt[9]  = '{32'h0000_2004, 1'b0, 32'h0, 32'h7777_8888, 1'b0,
               15, 4'b0100, 18, 1'b0, 32'h7777_8888, 17};
`ifdef APB_TIMEOUT_EN
    vt[10] = '{32'h0000_2008, 1'b0, 32'h0, 32'h9999_0000, 1'b0,
               16, 4'b0100, 19, 1'b1, 32'h7777_8888, 17};
`else
    vt[10] = '{32'h0000_2008, 1'b0, 32'h0, 32'h9999_0000, 1'b0,
               16, 4'b0100, 19, 1'b0, 32'h9999_0000, 18};
`endif
    vt[11] = '{32'h0000_2020, 1'b0, 32'h0, 32'h1111_1111, 1'b0,
               0, 4'b0100, 3, 1'b0, 32'h1111_1111, 2};
    vt[12] = '{32'h0000_1000, 1'b0, 32'h0, 32'h2222_2222, 1'b0,
               4, 4'b0010, -1, 1'b0, 32'h0, 2};
    vt[13] = '{32'h0000_0004, 1'b1, 32'h0F0F_0F0F, 32'h0, 1'b0,
               0, 4'b0001, 3, 1'b0, 32'h0000_0000, 2};

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hreadyout", 32'(ahb_out.hreadyout), 32'd1);
    chk("rst_hresp", 32'(ahb_out.hresp), 32'd0);
    chk("rst_hrdata", ahb_out.hrdata, 32'h0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'h0);
    hreset = 1'b0;
    in_reset = 1'b0;

    for (int i = 0; i < 11; i++) issue(vt[i]);
    noise();

    // Back-to-back, then reset during the second ACCESS
    issue(vt[11]);
    issue(vt[12]);
    n = 0;
    while (!penable && n < 50) begin
      @(negedge hclk);
      n++;
    end
    if (!penable)
      miss("reset_access_wait", "penable never rose, required 1");
    in_reset = 1'b1;
    hreset = 1'b1;
    @(negedge hclk);
    chk("rstmid_psel", 32'(psel), 32'd0);
    chk("rstmid_penable", 32'(penable), 32'd0);
    chk("rstmid_hreadyout", 32'(ahb_out.hreadyout), 32'd1);
    chk("rstmid_hresp", 32'(ahb_out.hresp), 32'd0);
    hreset = 1'b0;
    @(negedge hclk);
    in_reset = 1'b0;

    issue(vt[13]);
    wait_ready();
    repeat (4) @(negedge hclk);
    chk("rsp_q_left", rsp_q.size(), 32'd0);
    chk("apb_q_left", apb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
